// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and helpers for the sequence pattern player.
//                - state_t   : player FSM state encoding (IDLE/RUN/DONE)
//                - seg7_hex  : 4-bit value -> active-low {a..g} segment code
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Segment code for a blank count (digit 0), also the reset value.
    localparam logic [6:0] C_SEG_ZERO = 7'b0000001;

    // Active-low seven-segment encoding, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Clock-enable generator. While en is high the counter runs
//                0..DIV_MAX and tick is high for exactly the cycle in which
//                the counter holds DIV_MAX. tick is registered.
//  Ports       : clk   - system clock
//                rst_n - synchronous reset, active-low
//                en    - count enable
//                clr   - synchronous clear of counter and tick (wins over en)
//                tick  - one-cycle enable pulse every DIV_MAX+1 cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int DIV_MAX = 20000000,
    parameter int DIV_W   = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] C_MAX = DIV_W'(DIV_MAX);
    // tick is registered, so it is raised on the edge that loads C_MAX.
    localparam logic [DIV_W-1:0] C_PRE = DIV_W'(DIV_MAX - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            r_cnt  <= (r_cnt == C_MAX) ? '0 : r_cnt + DIV_W'(1);
            r_tick <= (r_cnt == C_PRE);
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/seq_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_player
//  Description : Plays a stored bit pattern (LSB first) into a serial
//                sequence detector, one bit per clock-enable tick, counts the
//                detector's active-low hits and shows the low nibble of the
//                count on a seven-segment display.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                load            - capture pattern/pat_len (IDLE/DONE only)
//                pattern,pat_len - bit pattern and length (0 or >PAT_W = PAT_W)
//                start, stop     - begin playback / abort to IDLE
//                det_n           - detector output, active-low hit
//                x, tick         - serial bit and its clock enable
//                busy, done      - in RUN / in DONE
//                hit_count, seg  - saturating hit count and its hex digit
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_player
    import seq_pkg::*;
#(
    parameter int DIV_MAX = 20000000,
    parameter int DIV_W   = 27,
    parameter int PAT_W   = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [4:0]       pat_len,
    input  logic             start,
    input  logic             stop,
    input  logic             det_n,
    output logic             x,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count,
    output logic [6:0]       seg
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int LEN_W = $clog2(PAT_W + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic [IDX_W-1:0] r_idx;
    logic             r_tick_d;
    logic             r_x;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_hits;
    logic [6:0]       r_seg;

    logic             w_tick;
    logic             w_load_take;
    logic             w_start_take;
    logic             w_sample;
    logic             w_last;
    logic             w_div_en;
    logic [IDX_W-1:0] w_idx_inc;
    logic [LEN_W-1:0] w_len_cap;
    logic [3:0]       w_nib;

    // Command arbitration: stop beats load beats start; RUN ignores both.
    assign w_load_take  = load && !stop && (r_state != ST_RUN);
    assign w_start_take = start && !stop && !load && (r_state != ST_RUN);

    // The detector has absorbed the ticked bit one cycle after the tick.
    assign w_sample  = (r_state == ST_RUN) && r_tick_d && !stop;
    assign w_idx_inc = r_idx + IDX_W'(1);
    assign w_last    = w_sample && ((LEN_W'(r_idx) + LEN_W'(1)) == r_len);

    // The divider only runs while we stay in RUN; any exit or entry clears
    // it so no tick can escape after stop/finish and RUN starts at count 0.
    assign w_div_en = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);

    always_comb begin
        w_len_cap = LEN_W'(PAT_W);
        if ((pat_len != 5'd0) && (32'(pat_len) <= PAT_W)) begin
            w_len_cap = LEN_W'(pat_len);
        end
    end

    generate
        if (CNT_W >= 4) begin : g_nib_wide
            assign w_nib = r_hits[3:0];
        end else begin : g_nib_narrow
            assign w_nib = {{(4 - CNT_W){1'b0}}, r_hits};
        end
    endgenerate

    tick_divider #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_div_en),
        .clr   (!w_div_en),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_take) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop)        w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (stop || w_load_take) w_state_nxt = ST_IDLE;
                else if (w_start_take)   w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pattern <= '0;
            r_len     <= LEN_W'(PAT_W);
            r_idx     <= '0;
            r_tick_d  <= 1'b0;
            r_x       <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hits    <= '0;
            r_seg     <= C_SEG_ZERO;
        end else begin
            r_tick_d <= w_tick;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
            r_seg    <= seg7_hex(w_nib);

            if (w_load_take) begin
                r_pattern <= pattern;
                r_len     <= w_len_cap;
            end

            if (w_start_take) begin
                r_idx  <= '0;
                r_hits <= '0;
                r_x    <= r_pattern[0];
            end else if (w_sample) begin
                if (!det_n && (r_hits != {CNT_W{1'b1}})) begin
                    r_hits <= r_hits + CNT_W'(1);
                end
                r_idx <= w_idx_inc;
                r_x   <= w_last ? 1'b1 : r_pattern[w_idx_inc];
            end

            // Line idles high whenever we are not playing.
            if (w_state_nxt != ST_RUN) begin
                r_x <= 1'b1;
            end
        end
    end

    assign x         = r_x;
    assign tick      = w_tick;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit_count = r_hits;
    assign seg       = r_seg;

endmodule
`default_nettype wire
